// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and rotate helper for the iterative ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_AND = 5'b00111;
  localparam logic [4:0] OP_OR  = 5'b01000;
  localparam logic [4:0] OP_SHR = 5'b01001;
  localparam logic [4:0] OP_SHL = 5'b01010;
  localparam logic [4:0] OP_ROR = 5'b01011;
  localparam logic [4:0] OP_ROL = 5'b01100;
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_DIV = 5'b10001;
  localparam logic [4:0] OP_NEG = 5'b10010;
  localparam logic [4:0] OP_NOT = 5'b10011;
  localparam logic [4:0] OP_INC = 5'b11111;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MUL_RUN = 2'd1;
  localparam logic [1:0] ST_DIV_RUN = 2'd2;
  localparam logic [1:0] ST_DIV_FIX = 2'd3;

  // A left rotate by amt equals a right rotate by (width - amt) mod width.
  function automatic int unsigned rol_as_ror(input int unsigned amt, input int unsigned width);
    return (width - (amt % width)) % width;
  endfunction

endpackage

// File: rtl/iter_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH steps after start.
module iter_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_next;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic [WIDTH:0]   trial;
  logic             fits;

  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    fits  = trial >= {1'b0, dvs_q};
    // When fits, the true difference is below the divisor, so WIDTH bits are exact.
    rem_next = fits ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == CW'(WIDTH)) begin
        run_q <= 1'b0;
      end else begin
        rem_q <= rem_next;
        quo_q <= {quo_q[WIDTH-2:0], fits};
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign done      = run_q && (cnt_q == CW'(WIDTH));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU driving the Z register: single-cycle ops, Booth MUL, restoring DIV.
module iter_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 5,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             div_zero,
  output logic             illegal_op
);
  import alu_pkg::*;

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic             busy_q, done_q, div_zero_q, illegal_q;
  logic [WIDTH-1:0] z_hi_q, z_lo_q, a_q, b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH:0]   mul_acc, mcand, acc_sum;
  logic [WIDTH-1:0] mul_mq;
  logic             mul_q1;
  logic [CW-1:0]    mul_cnt;
  logic             accept;

  logic             div_start, div_done;
  logic [WIDTH-1:0] a_mag, b_mag, div_quo, div_rem;

  assign accept    = start && (state == ST_IDLE) && !busy_q;
  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_mag     = b[WIDTH-1] ? -b : b;
  assign div_start = accept && (op == OP_DIV) && (|b);

  iter_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  logic [SHW-1:0]   sh;
  int unsigned      rot_amt;
  logic [WIDTH-1:0] sc_lo;
  logic             sc_illegal;

  always_comb begin
    sh         = b_q[SHW-1:0];
    rot_amt    = (op_q == OP_ROL) ? rol_as_ror(32'(sh), WIDTH) : 32'(sh);
    sc_lo      = '0;
    sc_illegal = 1'b0;
    case (op_q)
      OP_ADD:         sc_lo = a_q + b_q;
      OP_SUB:         sc_lo = a_q - b_q;
      OP_AND:         sc_lo = a_q & b_q;
      OP_OR:          sc_lo = a_q | b_q;
      OP_SHR:         sc_lo = a_q >> sh;
      OP_SHL:         sc_lo = a_q << sh;
      // Shift by WIDTH yields zero, so rotate by 0 falls out as a_q.
      OP_ROR, OP_ROL: sc_lo = (a_q >> rot_amt) | (a_q << (WIDTH - rot_amt));
      OP_NEG:         sc_lo = -a_q;
      OP_NOT:         sc_lo = ~a_q;
      OP_INC:         sc_lo = a_q + WIDTH'(1);
      default:        sc_illegal = 1'b1;
    endcase
  end

  // Radix-2 Booth: one guard bit in the accumulator keeps MIN*MIN exact.
  always_comb begin
    mcand = {a_q[WIDTH-1], a_q};
    case ({mul_mq[0], mul_q1})
      2'b01:   acc_sum = mul_acc + mcand;
      2'b10:   acc_sum = mul_acc - mcand;
      default: acc_sum = mul_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
      z_hi_q     <= '0;
      z_lo_q     <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mul_acc    <= '0;
      mul_mq     <= '0;
      mul_q1     <= 1'b0;
      mul_cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (busy_q) begin
            // Accepted last cycle and not iterative: single-cycle, illegal or DIV by zero.
            busy_q <= 1'b0;
            done_q <= 1'b1;
            if (op_q == OP_DIV) begin
              z_hi_q     <= a_q;
              z_lo_q     <= '1;
              div_zero_q <= 1'b1;
            end else begin
              z_hi_q    <= '0;
              z_lo_q    <= sc_lo;
              illegal_q <= sc_illegal;
            end
          end else if (accept) begin
            op_q       <= op;
            a_q        <= a;
            b_q        <= b;
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
            mul_acc    <= '0;
            mul_mq     <= b;
            mul_q1     <= 1'b0;
            mul_cnt    <= '0;
            if (op == OP_MUL) state <= ST_MUL_RUN;
            else if (div_start) state <= ST_DIV_RUN;
          end
        end
        ST_MUL_RUN: begin
          if (mul_cnt == CW'(WIDTH)) begin
            z_hi_q <= mul_acc[WIDTH-1:0];
            z_lo_q <= mul_mq;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            {mul_acc, mul_mq, mul_q1} <= {acc_sum[WIDTH], acc_sum, mul_mq};
            mul_cnt <= mul_cnt + CW'(1);
          end
        end
        ST_DIV_RUN: begin
          if (div_done) state <= ST_DIV_FIX;
        end
        default: begin
          // Quotient negative on sign mismatch; remainder follows the dividend.
          z_lo_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -div_quo : div_quo;
          z_hi_q <= a_q[WIDTH-1] ? -div_rem : div_rem;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign z_hi       = z_hi_q;
  assign z_lo       = z_lo_q;
  assign div_zero   = div_zero_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_iter_alu.sv
// Randomized self-checking bench for iter_alu against a plain-arithmetic reference model.
module tb_iter_alu;

  localparam logic [4:0] C_ADD = 5'b00101, C_SUB = 5'b00110, C_AND = 5'b00111, C_OR  = 5'b01000;
  localparam logic [4:0] C_SHR = 5'b01001, C_SHL = 5'b01010, C_ROR = 5'b01011, C_ROL = 5'b01100;
  localparam logic [4:0] C_MUL = 5'b10000, C_DIV = 5'b10001, C_NEG = 5'b10010, C_NOT = 5'b10011;
  localparam logic [4:0] C_INC = 5'b11111;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero, illegal_op;
  logic [31:0] z_hi, z_lo;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(32), .OPW(5), .SHW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .z_hi       (z_hi),
    .z_lo       (z_lo),
    .div_zero   (div_zero),
    .illegal_op (illegal_op)
  );

  function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                output int lat, output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz, output logic ill);
    longint sx, sy, p, q, r;
    int s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s = int'(y[4:0]);
    lat = 1; hi = '0; lo = '0; dz = 1'b0; ill = 1'b0;
    case (o)
      C_ADD: lo = x + y;
      C_SUB: lo = x - y;
      C_AND: lo = x & y;
      C_OR:  lo = x | y;
      C_SHR: lo = x >> s;
      C_SHL: lo = x << s;
      C_ROR: lo = (s == 0) ? x : ((x >> s) | (x << (32 - s)));
      C_ROL: lo = (s == 0) ? x : ((x << s) | (x >> (32 - s)));
      C_NEG: lo = 32'd0 - x;
      C_NOT: lo = ~x;
      C_INC: lo = x + 32'd1;
      C_MUL: begin p = sx * sy; hi = p[63:32]; lo = p[31:0]; lat = 33; end
      C_DIV: begin
        if (y == 32'd0) begin
          lo = '1; hi = x; dz = 1'b1;
        end else begin
          q = sx / sy; r = sx % sy;
          lo = q[31:0]; hi = r[31:0]; lat = 34;
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return MIN;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Launches one op now (away from the edge), then waits for done with a bounded budget.
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output logic ill, output logic busy_ok);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    lat = 0; busy_ok = 1'b1;
    do begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end while (done !== 1'b1 && lat < 100);
    if (busy !== 1'b0) busy_ok = 1'b0;
    hi = z_hi; lo = z_lo; dz = div_zero; ill = illegal_op;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op = C_ADD; a = 32'd1; b = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, div_zero, illegal_op, z_hi, z_lo} !== 68'd0) begin
      miscompares++;
      $display("FAIL reset_hold busy=%b done=%b z=%h_%h required all zero", busy, done, z_hi, z_lo);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, z_hi, z_lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_idle busy=%b done=%b z=%h_%h required all zero", busy, done, z_hi, z_lo);
    end
  endtask

  task automatic test_single();
    logic [4:0] ops[11] = '{C_ADD, C_SUB, C_AND, C_OR, C_SHR, C_SHL, C_ROR, C_ROL, C_NEG,
                            C_NOT, C_INC};
    logic [4:0] o; logic [31:0] x, y, hi, lo, ehi, elo;
    logic dz, ill, edz, eill, bok; int lat, elat;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin o = C_ADD; x = 32'hFFFF_FFFF; y = 32'd2; end
      else if (i == 1) begin o = C_ROL; x = 32'h8000_0001; y = 32'd33; end
      else if (i == 2) begin o = C_ROR; x = 32'h1234_5678; y = 32'd0; end
      else begin o = ops[$urandom_range(0, 10)]; x = rand_operand(); y = rand_operand(); end
      model(o, x, y, elat, ehi, elo, edz, eill);
      run_op(o, x, y, lat, hi, lo, dz, ill, bok);
      vectors++;
      if ({lat, hi, lo, dz, ill, bok} !== {elat, ehi, elo, edz, eill, 1'b1}) begin
        miscompares++;
        $display("FAIL single op=%b a=%h b=%h got lat=%0d z=%h_%h dz=%b ill=%b busy_ok=%b want lat=%0d z=%h_%h dz=%b ill=%b",
                 o, x, y, lat, hi, lo, dz, ill, bok, elat, ehi, elo, edz, eill);
      end
    end
  endtask

  task automatic test_mul();
    logic [31:0] x, y, hi, lo, ehi, elo;
    logic dz, ill, edz, eill, bok; int lat, elat;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin x = 32'hFFFF_FFFD; y = 32'd7; end
      else if (i == 1) begin x = MIN; y = MIN; end
      else if (i == 2) begin x = MIN; y = 32'hFFFF_FFFF; end
      else begin x = rand_operand(); y = rand_operand(); end
      model(C_MUL, x, y, elat, ehi, elo, edz, eill);
      run_op(C_MUL, x, y, lat, hi, lo, dz, ill, bok);
      vectors++;
      if ({lat, hi, lo, dz, ill, bok} !== {elat, ehi, elo, edz, eill, 1'b1}) begin
        miscompares++;
        $display("FAIL mul a=%h b=%h got lat=%0d z=%h_%h busy_ok=%b want lat=%0d z=%h_%h",
                 x, y, lat, hi, lo, bok, elat, ehi, elo);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] x, y, hi, lo, ehi, elo;
    logic dz, ill, edz, eill, bok; int lat, elat;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin x = 32'hFFFF_FFF9; y = 32'd2; end
      else if (i == 1) begin x = MIN; y = 32'hFFFF_FFFF; end
      else if (i == 2) begin x = 32'd7; y = 32'hFFFF_FFFE; end
      else if (i == 3) begin x = MIN; y = MIN; end
      else begin x = rand_operand(); y = rand_operand(); end
      model(C_DIV, x, y, elat, ehi, elo, edz, eill);
      run_op(C_DIV, x, y, lat, hi, lo, dz, ill, bok);
      vectors++;
      if ({lat, hi, lo, dz, ill, bok} !== {elat, ehi, elo, edz, eill, 1'b1}) begin
        miscompares++;
        $display("FAIL div a=%h b=%h got lat=%0d z=%h_%h dz=%b ill=%b busy_ok=%b want lat=%0d z=%h_%h dz=%b",
                 x, y, lat, hi, lo, dz, ill, bok, elat, ehi, elo, edz);
      end
    end
  endtask

  task automatic test_div_zero_illegal();
    logic [4:0] o; logic [31:0] x, hi, lo, ehi, elo;
    logic dz, ill, edz, eill, bok; int lat, elat;
    run_op(C_DIV, 32'd5, 32'd0, lat, hi, lo, dz, ill, bok);
    vectors++;
    if ({lat, hi, lo, dz, ill, bok} !== {32'd1, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL div_zero got lat=%0d z=%h_%h dz=%b ill=%b want lat=1 z=00000005_ffffffff dz=1",
               lat, hi, lo, dz, ill);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({div_zero, illegal_op, z_hi, z_lo} !== {1'b1, 1'b0, 32'd5, 32'hFFFF_FFFF}) begin
      miscompares++;
      $display("FAIL div_zero_hold got dz=%b ill=%b z=%h_%h want dz=1 held", div_zero, illegal_op,
               z_hi, z_lo);
    end
    for (int i = 0; i < 4; i++) begin
      o = (i == 0) ? 5'b01101 : 5'($urandom);
      x = $urandom;
      model(o, x, 32'd0, elat, ehi, elo, edz, eill);
      run_op(o, x, 32'd0, lat, hi, lo, dz, ill, bok);
      vectors++;
      if ({lat, hi, lo, dz, ill, bok} !== {elat, ehi, elo, edz, eill, 1'b1}) begin
        miscompares++;
        $display("FAIL opcode_sweep op=%b got lat=%0d z=%h_%h dz=%b ill=%b want lat=%0d z=%h_%h dz=%b ill=%b",
                 o, lat, hi, lo, dz, ill, elat, ehi, elo, edz, eill);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] ehi, elo; logic edz, eill; int lat, elat;
    model(C_MUL, 32'hFFFF_FFFD, 32'd7, elat, ehi, elo, edz, eill);
    start = 1'b1; op = C_MUL; a = 32'hFFFF_FFFD; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    start = 1'b1; op = C_ADD; a = 32'd100; b = 32'd200;
    @(posedge clk); #1;
    lat++; start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    vectors++;
    if ({lat, z_hi, z_lo} !== {elat, ehi, elo}) begin
      miscompares++;
      $display("FAIL busy_ignore got lat=%0d z=%h_%h want lat=%0d z=%h_%h", lat, z_hi, z_lo,
               elat, ehi, elo);
    end
    @(posedge clk); #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL busy_no_queue got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo; logic dz, ill, bok; int lat, seen;
    run_op(C_ADD, 32'h1111_1111, 32'h2222_2222, lat, hi, lo, dz, ill, bok);
    start = 1'b1; op = C_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if ({busy, done, div_zero, illegal_op, z_hi, z_lo} !== 68'd0) begin
      miscompares++;
      $display("FAIL reset_mid got busy=%b done=%b z=%h_%h want all zero", busy, done, z_hi, z_lo);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_mid_abort got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops[6] = '{C_MUL, C_DIV, C_ADD, C_INC, C_DIV, C_MUL};
    logic [31:0] x, y, hi, lo, ehi, elo;
    logic dz, ill, edz, eill, bok; int lat, elat;
    for (int i = 0; i < 6; i++) begin
      x = rand_operand();
      y = (i == 4) ? 32'd0 : rand_operand();
      model(ops[i], x, y, elat, ehi, elo, edz, eill);
      run_op(ops[i], x, y, lat, hi, lo, dz, ill, bok);
      vectors++;
      if ({lat, hi, lo, dz, ill, bok} !== {elat, ehi, elo, edz, eill, 1'b1}) begin
        miscompares++;
        $display("FAIL back_to_back step=%0d op=%b a=%h b=%h got lat=%0d z=%h_%h dz=%b want lat=%0d z=%h_%h dz=%b",
                 i, ops[i], x, y, lat, hi, lo, dz, elat, ehi, elo, edz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_div_zero_illegal();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
